// File: rtl/rdyack_arb_pkg.sv
// Shared types and helpers for the round-robin rdy/ack arbiter.
package rdyack_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  // Width of a requester index; never narrower than one bit
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rdyack_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit found when
// scanning from ptr upwards and wrapping to 0. The request vector is doubled
// so the wrap needs no modulo arithmetic on the scan index.
module rdyack_rr_pick
  import rdyack_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx
);

  localparam int DW = $clog2(2 * N);

  logic [2*N-1:0] reqDbl;
  logic [DW-1:0]  bitPos;
  logic           found;

  // Find-first-set over the doubled vector starting at ptr; idx falls back to ptr
  always_comb begin
    reqDbl = {req, req};
    any    = |req;
    idx    = ptr;
    found  = 1'b0;
    bitPos = '0;
    for (int k = 0; k < N; k++) begin
      bitPos = DW'(ptr) + DW'(k);
      if (!found && reqDbl[bitPos]) begin
        found = 1'b1;
        if (bitPos >= DW'(N)) begin
          bitPos = bitPos - DW'(N);
        end
        idx = SW'(bitPos);
      end
    end
  end

endmodule

// File: rtl/rdyack_rr_arbiter.sv
// Round-robin arbiter sharing one rdy/ack channel among N sources, with the
// grant locked across multi-beat packets. Optional per-requester completed
// packet counters are built when RDYACK_ARB_CNT_EN is defined.
module rdyack_rr_arbiter
  import rdyack_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  localparam int SW   = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  src_rdys,
  output logic [N-1:0]  src_acks,
  input  logic [N-1:0]  src_lasts,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic [SW-1:0] dst_sel,
  output logic          dst_last,
  output logic          busy
`ifdef RDYACK_ARB_CNT_EN
  ,
  output logic [N*CNT_W-1:0] grant_cnt
`endif
);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lockSel_q, lockSel_d;

  logic          pickAny;
  logic [SW-1:0] pickIdx;
  logic          handshake;
  logic          pktDone;

  rdyack_rr_pick #(.N(N)) uPick (
    .req (src_rdys),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // Successor index with an explicit wrap so N need not be a power of two
  function automatic logic [SW-1:0] nextIdx(input logic [SW-1:0] i);
    return (i == SW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // Register state, priority pointer and locked requester
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      lockSel_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lockSel_q <= lockSel_d;
    end
  end

  // Select the source, gate ack to it, and decide lock entry/exit
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lockSel_d = lockSel_q;
    src_acks  = '0;
    if (state_q == ARB_LOCK) begin
      dst_sel = lockSel_q;
      dst_rdy = src_rdys[lockSel_q];
    end else begin
      dst_sel = pickIdx;
      dst_rdy = pickAny;
    end
    dst_last  = src_lasts[dst_sel];
    handshake = dst_rdy && dst_ack;
    pktDone   = handshake && dst_last;
    if (handshake) begin
      src_acks[dst_sel] = 1'b1;
    end
    if (state_q == ARB_IDLE) begin
      if (dst_rdy) begin
        if (pktDone) begin
          ptr_d = nextIdx(dst_sel);
        end else begin
          state_d   = ARB_LOCK;
          lockSel_d = dst_sel;
        end
      end
    end else if (pktDone) begin
      state_d = ARB_IDLE;
      ptr_d   = nextIdx(lockSel_q);
    end
  end

  assign busy = (state_q == ARB_LOCK);

`ifdef RDYACK_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];

  // Count completed packets per requester, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pktDone && (dst_sel == SW'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : gCntOut
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_rdyack_rr_arbiter.sv
// Self-checking bench for rdyack_rr_arbiter: directed scenarios with fixed
// expectations plus randomized traffic against a behavioural model.
// Counter checks are compiled when RDYACK_ARB_CNT_EN is defined.
module tb_rdyack_rr_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_rdys, src_acks, src_lasts;
  logic       dst_rdy, dst_ack, dst_last, busy;
  logic [1:0] dst_sel;

  logic [2:0] rdys3, acks3, lasts3;
  logic       rdy3, ack3, last3, busy3;
  logic [1:0] sel3;

`ifdef RDYACK_ARB_CNT_EN
  logic [N*CNT_W-1:0] grantCnt;
  logic [47:0]        grantCnt3;
`endif

  int checks = 0;
  int errors = 0;

  rdyack_rr_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_rdys  (src_rdys),
    .src_acks  (src_acks),
    .src_lasts (src_lasts),
    .dst_rdy   (dst_rdy),
    .dst_ack   (dst_ack),
    .dst_sel   (dst_sel),
    .dst_last  (dst_last),
    .busy      (busy)
`ifdef RDYACK_ARB_CNT_EN
    ,
    .grant_cnt (grantCnt)
`endif
  );

  rdyack_rr_arbiter #(.N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .src_rdys  (rdys3),
    .src_acks  (acks3),
    .src_lasts (lasts3),
    .dst_rdy   (rdy3),
    .dst_ack   (ack3),
    .dst_sel   (sel3),
    .dst_last  (last3),
    .busy      (busy3)
`ifdef RDYACK_ARB_CNT_EN
    ,
    .grant_cnt (grantCnt3)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: pointer, lock flag/owner and saturating packet counts
  int         mPtr = 0;
  bit         mLock = 1'b0;
  int         mOwner = 0;
  int         mCnt [N];
  int         mSel;
  logic [8:0] mOut;

  // Expected {dst_rdy, dst_sel, src_acks, dst_last, busy} for current inputs
  function automatic logic [8:0] modelOut(logic [3:0] r, logic [3:0] l, logic a);
    int   sel;
    logic rdy;
    logic [3:0] acks;
    if (mLock) begin
      sel = mOwner;
      rdy = r[sel];
    end else begin
      rdy = |r;
      sel = mPtr;
      for (int i = N - 1; i >= 0; i--) begin
        if (r[(mPtr + i) % N]) sel = (mPtr + i) % N;
      end
    end
    acks = (rdy && a) ? 4'(1 << sel) : 4'b0000;
    return {rdy, 2'(sel), acks, l[sel], mLock};
  endfunction

  // Advance the model on each rising edge
  always @(posedge clk) begin
    mOut = modelOut(src_rdys, src_lasts, dst_ack);
    if (rst) begin
      mPtr = 0;
      mLock = 1'b0;
      mOwner = 0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
    end else if (mOut[8]) begin
      mSel = int'(mOut[7:6]);
      if (dst_ack && mOut[1]) begin
        mPtr = (mSel + 1) % N;
        mLock = 1'b0;
        if (mCnt[mSel] < CMAX) mCnt[mSel]++;
      end else begin
        mLock = 1'b1;
      end
      mOwner = mSel;
    end
  end

  task automatic test_reset();
    rst = 1'b1; src_rdys = 4'b0000; src_lasts = 4'b0000; dst_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b required %b", {dst_rdy, dst_sel, src_acks, dst_last, busy}, 9'b0);
    end
    checks++;
    if ({rdy3, sel3, acks3, busy3} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_state_n3: got %b required %b", {rdy3, sel3, acks3, busy3}, 8'b0);
    end
`ifdef RDYACK_ARB_CNT_EN
    checks++;
    if (grantCnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %h required 0", grantCnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dst_rdy, src_acks, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL ack_masked_idle: got %b required %b", {dst_rdy, src_acks, busy}, 6'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    logic [8:0] exp [5] = '{9'b1_01_0010_1_0, 9'b1_11_1000_1_0, 9'b1_01_0010_1_0,
                            9'b1_11_1000_1_0, 9'b0_00_0000_1_0};
    for (int i = 0; i < 5; i++) begin
      src_rdys = (i < 4) ? 4'b1010 : 4'b0000; src_lasts = 4'b1111; dst_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL alternate beat %0d: got %b required %b", i, {dst_rdy, dst_sel, src_acks, dst_last, busy}, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multibeat();
    logic [3:0] r [5] = '{4'b0100, 4'b0101, 4'b0001, 4'b0101, 4'b0001};
    logic [3:0] l [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
    logic [8:0] exp [5] = '{9'b1_10_0100_0_0, 9'b1_10_0100_0_1, 9'b0_10_0000_0_1,
                            9'b1_10_0100_1_1, 9'b1_00_0001_1_0};
    for (int i = 0; i < 5; i++) begin
      src_rdys = r[i]; src_lasts = l[i]; dst_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL multibeat beat %0d: got %b required %b", i, {dst_rdy, dst_sel, src_acks, dst_last, busy}, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_no_ack();
    logic [3:0] r [7] = '{4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
    logic       a [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] exp [7] = '{9'b1_00_0000_1_0, 9'b1_00_0000_1_1, 9'b1_00_0000_1_1,
                            9'b1_00_0000_1_1, 9'b1_00_0000_1_1, 9'b1_00_0001_1_1,
                            9'b1_11_1000_1_0};
    rst = 1'b1; src_rdys = 4'b0000; dst_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      src_rdys = r[i]; src_lasts = 4'b1111; dst_ack = a[i];
      @(negedge clk);
      checks++;
      if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL hold_no_ack cycle %0d: got %b required %b", i, {dst_rdy, dst_sel, src_acks, dst_last, busy}, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midpacket();
    logic [3:0] r [5] = '{4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic [3:0] l [5] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic       rs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] exp [5] = '{9'b1_10_0100_1_0, 9'b1_01_0010_0_0, 9'b1_01_0010_0_1,
                            9'b0_00_0000_0_0, 9'b1_00_0001_1_0};
    for (int i = 0; i < 5; i++) begin
      src_rdys = r[i]; src_lasts = l[i]; dst_ack = 1'b1; rst = rs[i];
      @(negedge clk);
      checks++;
      if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL reset_midpacket cycle %0d: got %b required %b", i, {dst_rdy, dst_sel, src_acks, dst_last, busy}, exp[i]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_n3();
    rdys3 = 3'b111; lasts3 = 3'b111; ack3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sel3 !== 2'(i % 3) || acks3 !== 3'(1 << (i % 3))) begin
        errors++;
        $display("[TB] FAIL wrap_n3 grant %0d: got sel=%0d acks=%b required sel=%0d acks=%b", i, sel3, acks3, i % 3, 3'(1 << (i % 3)));
      end
      @(posedge clk); #1;
    end
    rdys3 = 3'b000; ack3 = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] exp;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      src_rdys  = 4'($urandom);
      src_lasts = 4'($urandom);
      dst_ack   = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      exp = modelOut(src_rdys, src_lasts, dst_ack);
      checks++;
      if ({dst_rdy, dst_sel, src_acks, dst_last, busy} !== exp) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b required %b", i, {dst_rdy, dst_sel, src_acks, dst_last, busy}, exp);
      end
`ifdef RDYACK_ARB_CNT_EN
      for (int k = 0; k < N; k++) begin
        checks++;
        if (int'(grantCnt[k*CNT_W +: CNT_W]) != mCnt[k]) begin
          errors++;
          $display("[TB] FAIL random_count%0d cycle %0d: got %0d required %0d", k, i, grantCnt[k*CNT_W +: CNT_W], mCnt[k]);
        end
      end
`endif
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

`ifdef RDYACK_ARB_CNT_EN
  task automatic test_counter_saturate();
    rst = 1'b1; src_rdys = 4'b0000; dst_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_rdys = 4'b0010; src_lasts = 4'b1111; dst_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (dst_sel !== 2'd1 || src_acks !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL counter_grant %0d: got sel=%0d acks=%b required sel=1 acks=0010", i, dst_sel, src_acks);
      end
      @(posedge clk); #1;
    end
    src_rdys = 4'b0000;
    @(negedge clk);
    checks++;
    if (grantCnt !== 8'b00_00_11_00) begin
      errors++;
      $display("[TB] FAIL counter_saturate: got %b required %b", grantCnt, 8'b00_00_11_00);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    src_rdys = '0; src_lasts = '0; dst_ack = 1'b0;
    rdys3 = '0; lasts3 = '0; ack3 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_wrap_n3();
    test_alternate();
    test_multibeat();
    test_hold_no_ack();
    test_reset_midpacket();
    test_random();
`ifdef RDYACK_ARB_CNT_EN
    test_counter_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
